// File: rtl/dmem_arbiter.sv
// Shares one single-ported data memory between the core and the I/O requester; 3-cycle access, 2-cycle trap for out-of-range addresses.
// Optional round-robin arbitration via DMEM_ARB_RR_EN (default build: fixed priority, core wins).
module dmem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [15:0] c_addr,
  input  logic [15:0] c_din,
  output logic        c_ack,
  output logic        c_err,
  output logic [15:0] c_rdata,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_din,
  output logic        i_ack,
  output logic        i_err,
  output logic [15:0] i_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_wea,
  input  logic [15:0] mem_douta,
  output logic        busy,
  output logic [7:0]  exc_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_io;
  logic        r_err;
  logic        r_c_ack;
  logic        r_c_err;
  logic [15:0] r_c_rdata;
  logic        r_i_ack;
  logic        r_i_err;
  logic [15:0] r_i_rdata;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_din;
  logic        r_mem_wea;
  logic [7:0]  r_exc;

  logic        w_any;
  logic        w_pick_io;
  logic [15:0] w_addr;
  logic [15:0] w_din;
  logic        w_we;
  logic        w_oor;

`ifdef DMEM_ARB_RR_EN
  logic        r_last_io;
  // On a tie the requester not granted most recently wins.
  assign w_pick_io = i_req & (~c_req | ~r_last_io);
`else
  assign w_pick_io = i_req & ~c_req;
`endif

  assign w_any  = c_req | i_req;
  assign w_addr = w_pick_io ? i_addr : c_addr;
  assign w_din  = w_pick_io ? i_din  : c_din;
  assign w_we   = w_pick_io ? i_we   : c_we;
  assign w_oor  = |w_addr[15:14];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_io       <= 1'b0;
      r_err      <= 1'b0;
      r_c_ack    <= 1'b0;
      r_c_err    <= 1'b0;
      r_c_rdata  <= 16'h0000;
      r_i_ack    <= 1'b0;
      r_i_err    <= 1'b0;
      r_i_rdata  <= 16'h0000;
      r_mem_addr <= 16'h0000;
      r_mem_din  <= 16'h0000;
      r_mem_wea  <= 1'b0;
      r_exc      <= 8'h00;
`ifdef DMEM_ARB_RR_EN
      r_last_io  <= 1'b1;
`endif
    end else begin
      r_c_ack <= 1'b0;
      r_c_err <= 1'b0;
      r_i_ack <= 1'b0;
      r_i_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_io <= w_pick_io;
`ifdef DMEM_ARB_RR_EN
            r_last_io <= w_pick_io;
`endif
            if (w_oor) begin
              // Trapped access never touches memory; skip straight to the response.
              r_err   <= 1'b1;
              r_state <= S_RESP;
              if (r_exc != 8'hFF) r_exc <= r_exc + 8'd1;
            end else begin
              r_err      <= 1'b0;
              r_mem_addr <= w_addr;
              r_mem_din  <= w_din;
              r_mem_wea  <= w_we;
              r_state    <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          r_mem_wea <= 1'b0;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          if (r_io) begin
            r_i_ack <= 1'b1;
            r_i_err <= r_err;
            if (!r_err) r_i_rdata <= mem_douta;
          end else begin
            r_c_ack <= 1'b1;
            r_c_err <= r_err;
            if (!r_err) r_c_rdata <= mem_douta;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign c_ack     = r_c_ack;
  assign c_err     = r_c_err;
  assign c_rdata   = r_c_rdata;
  assign i_ack     = r_i_ack;
  assign i_err     = r_i_err;
  assign i_rdata   = r_i_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;
  assign mem_wea   = r_mem_wea;
  assign busy      = (r_state != S_IDLE);
  assign exc_count = r_exc;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed cases plus randomized two-requester traffic against a shadow-memory model.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [15:0] c_addr = 16'h0, c_din = 16'h0;
  logic        c_ack, c_err;
  logic [15:0] c_rdata;
  logic        i_req = 1'b0, i_we = 1'b0;
  logic [15:0] i_addr = 16'h0, i_din = 16'h0;
  logic        i_ack, i_err;
  logic [15:0] i_rdata;
  logic [15:0] mem_addr, mem_din, mem_douta;
  logic        mem_wea, busy;
  logic [7:0]  exc_count;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_din(c_din),
    .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_din(i_din),
    .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wea(mem_wea),
    .mem_douta(mem_douta), .busy(busy), .exc_count(exc_count)
  );

  // Synchronous-read, write-first data memory (only the low 128 words are exercised).
  logic [15:0] mem [0:127] = '{default: 16'h0};
  always @(posedge clk) begin
    if (mem_wea) begin
      mem[mem_addr[6:0]] <= mem_din;
      mem_douta          <= mem_din;
    end else begin
      mem_douta <= mem[mem_addr[6:0]];
    end
  end

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        qc[$];
  exp_t        qi[$];
  logic [15:0] sh [0:127] = '{default: 16'h0};
  logic [15:0] lr_c = 16'h0, lr_i = 16'h0;
  int          exc_m = 0;
  int          n_checks = 0, n_errors = 0;
  int          wea_cnt = 0;
  logic [15:0] cur_c = 16'h0, cur_i = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every ack and checks the always-true rules.
  always @(negedge clk) begin : mon
    exp_t e;
    if (mem_wea) wea_cnt++;
    if (reset) begin
      cur_c = 16'h0;
      cur_i = 16'h0;
    end else begin
      chk("wea_outside_busy", {31'b0, mem_wea & ~busy}, 0);
      chk("c_err_without_ack", {31'b0, c_err & ~c_ack}, 0);
      chk("i_err_without_ack", {31'b0, i_err & ~i_ack}, 0);
      chk("dual_ack", {31'b0, c_ack & i_ack}, 0);
      if (c_ack) begin
        if (qc.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL c_unexpected_ack: got ack with rdata %0h, expected no ack", c_rdata);
        end else begin
          e = qc.pop_front();
          chk("c_rdata", {16'h0, c_rdata}, {16'h0, e.rdata});
          chk("c_err", {31'b0, c_err}, {31'b0, e.err});
          cur_c = e.rdata;
          chk("i_rdata_hold", {16'h0, i_rdata}, {16'h0, cur_i});
        end
      end
      if (i_ack) begin
        if (qi.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL i_unexpected_ack: got ack with rdata %0h, expected no ack", i_rdata);
        end else begin
          e = qi.pop_front();
          chk("i_rdata", {16'h0, i_rdata}, {16'h0, e.rdata});
          chk("i_err", {31'b0, i_err}, {31'b0, e.err});
          cur_i = e.rdata;
          chk("c_rdata_hold", {16'h0, c_rdata}, {16'h0, cur_c});
        end
      end
    end
  end

  // Reference model: out-of-range traps keep old rdata; valid accesses see the shadow memory.
  function automatic exp_t model(input bit io, input bit we, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    if (a[15:14] != 2'b00) begin
      e.err   = 1'b1;
      e.rdata = io ? lr_i : lr_c;
      if (exc_m < 255) exc_m++;
    end else begin
      e.err = 1'b0;
      if (we) sh[a[6:0]] = d;
      e.rdata = sh[a[6:0]];
      if (io) lr_i = e.rdata; else lr_c = e.rdata;
    end
    return e;
  endfunction

  task automatic xact(input bit io, input bit we, input logic [15:0] a, input logic [15:0] d, input int lat);
    exp_t e;
    int   n;
    bit   got;
    e = model(io, we, a, d);
    @(negedge clk);
    if (io) begin
      qi.push_back(e);
      i_req = 1'b1; i_we = we; i_addr = a; i_din = d;
    end else begin
      qc.push_back(e);
      c_req = 1'b1; c_we = we; c_addr = a; c_din = d;
    end
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = io ? i_ack : c_ack;
    end
    if (io) i_req = 1'b0; else c_req = 1'b0;
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL ack_timeout: requester %0d got no ack in 40 cycles, expected ack", io);
    end else if (lat > 0) begin
      chk("ack_latency", n, lat);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; c_req = 1'b0; i_req = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_acks", {28'b0, c_ack, i_ack, c_err, i_err}, 0);
    chk("rst_rdata", {c_rdata, i_rdata}, 0);
    chk("rst_mem", {mem_addr, mem_din}, 0);
    chk("rst_wea_exc", {23'b0, mem_wea, exc_count}, 0);
    @(negedge clk);
    reset = 1'b0;
    lr_c = 16'h0; lr_i = 16'h0; exc_m = 0;
  endtask

  task automatic rnd_xact(input bit io);
    logic [1:0]  hi;
    logic [15:0] a;
    bit          we;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    we = 1'($urandom);
    if ($urandom_range(0, 7) == 0) begin
      hi = 2'($urandom_range(1, 3));
      a  = {hi, 14'($urandom)};
    end else begin
      a = io ? 16'($urandom_range(64, 127)) : 16'($urandom_range(0, 63));
    end
    xact(io, we, a, 16'($urandom), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin : main
    int   w0, n;
    exp_t ec, ei;
    bit   order[$];

    do_reset();

    w0 = wea_cnt;
    repeat (10) @(negedge clk);
    chk("idle_wea", wea_cnt - w0, 0);
    chk("idle_busy", {31'b0, busy}, 0);

    w0 = wea_cnt;
    xact(0, 1'b1, 16'd1, 16'd100, 3);
    chk("write_wea_cycles", wea_cnt - w0, 1);
    xact(0, 1'b0, 16'd1, 16'd0, 3);

    xact(1, 1'b1, 16'd2, 16'd10000, 3);
    xact(0, 1'b0, 16'd2, 16'd0, 3);

    do_reset();
    xact(0, 1'b0, 16'd1, 16'd0, 3);
    w0 = wea_cnt;
    xact(0, 1'b0, 16'h4000, 16'd0, 2);
    xact(0, 1'b1, 16'hC000, 16'd55, 2);
    xact(0, 1'b0, 16'h8000, 16'd0, 2);
    chk("err_wea", wea_cnt - w0, 0);
    chk("exc_count_3", {24'b0, exc_count}, 3);
    for (int k = 0; k < 260; k++) xact(0, 1'($urandom), 16'h4000 | 16'($urandom_range(0, 16383)), 16'($urandom), 2);
    chk("exc_count_sat", {24'b0, exc_count}, 255);

    do_reset();
    fork
      for (int k = 0; k < 120; k++) rnd_xact(0);
      for (int k = 0; k < 120; k++) rnd_xact(1);
    join
    repeat (3) @(negedge clk);
    chk("exc_count_rand", {24'b0, exc_count}, exc_m);

    // Reset while a core read is in its memory cycle: no ack may follow.
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'd1;
    @(negedge clk);
    chk("mid_busy_before", {31'b0, busy}, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_busy_after", {31'b0, busy}, 0);
    chk("mid_no_ack", {31'b0, c_ack}, 0);
    c_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    lr_c = 16'h0; lr_i = 16'h0; exc_m = 0;
    xact(0, 1'b0, 16'd1, 16'd0, 3);

    // Both requesters held high from reset.
    do_reset();
    ec = model(0, 1'b0, 16'd5, 16'd0);
    ei = model(1, 1'b0, 16'd70, 16'd0);
    for (int k = 0; k < 6; k++) begin
      if (RR && (k % 2 == 1)) qi.push_back(ei);
      else qc.push_back(ec);
    end
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'd5;
    i_req = 1'b1; i_we = 1'b0; i_addr = 16'd70;
    n = 0;
    while (order.size() < 6 && n < 100) begin
      @(negedge clk);
      n++;
      if (c_ack || i_ack) order.push_back(i_ack);
    end
    c_req = 1'b0; i_req = 1'b0;
    chk("hold_ack_count", order.size(), 6);
    for (int k = 0; k < order.size(); k++)
      chk("hold_order", {31'b0, order[k]}, RR ? (k % 2) : 0);

    repeat (5) @(negedge clk);
    chk("qc_drained", qc.size(), 0);
    chk("qi_drained", qi.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
